// File: rtl/countdown_timer_pkg.sv
// countdown_timer shared types.
// State encoding and width defaults for the timer slice.
package countdown_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer command/status bundle.
// master drives commands, slave is the timer.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic             i_stop;
    logic             i_en;
    logic             i_reload;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] o_cnt;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start,
        output i_stop,
        output i_en,
        output i_reload,
        output i_load_val,
        input  o_cnt,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_stop,
        input  i_en,
        input  i_reload,
        input  i_load_val,
        output o_cnt,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/countdown_timer_down_counter_ld.sv
// Loadable down-counter with async clear.
// Load wins over decrement; never steps below zero.
module down_counter_ld #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             is_one
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign is_one = (cnt == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer top: IDLE/RUN FSM, reload/mode regs, done flop.
// Counter datapath lives in down_counter_ld.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    countdown_timer_if.slave     bus
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] reload_q;
    logic             mode_q;
    logic             done_q;
    logic             done_d;

    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             dec;
    logic [WIDTH-1:0] cnt;
    logic             is_one;

    logic             run;
    logic             stop;
    logic             go;
    logic             tick;
    logic             zero_ld;

    // Mutually exclusive command terms encode stop > start > tick.
    assign run     = (state_q == ST_RUN);
    assign stop    = bus.i_stop;
    assign go      = bus.i_start & ~bus.i_stop;
    assign tick    = run & bus.i_en & ~bus.i_start & ~bus.i_stop;
    assign zero_ld = (bus.i_load_val == '0);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        ld_val  = bus.i_load_val;
        dec     = 1'b0;
        unique case (1'b1)
            stop: begin
                state_d = ST_IDLE;
            end
            go: begin
                ld      = 1'b1;
                done_d  = zero_ld;
                state_d = zero_ld ? ST_IDLE : ST_RUN;
            end
            tick: begin
                dec = 1'b1;
                if (is_one) begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        ld     = 1'b1;
                        ld_val = reload_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reload_q <= '0;
            mode_q   <= 1'b0;
        end else if (go) begin
            reload_q <= bus.i_load_val;
            mode_q   <= bus.i_reload;
        end
    end

    down_counter_ld #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (i_rst_n),
        .load     (ld),
        .load_val (ld_val),
        .dec      (dec),
        .cnt      (cnt),
        .is_one   (is_one)
    );

    assign bus.o_cnt  = cnt;
    assign bus.o_busy = run;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer (WIDTH=8).
module tb_countdown_timer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    countdown_timer_if #(.WIDTH(8)) bus ();

    countdown_timer #(
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       en;
        logic       reload;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic p, input logic e,
                       input logic r, input logic [7:0] lv,
                       input logic [7:0] c, input logic b,
                       input logic d, input string n);
        vec_t v;
        v.start = s; v.stop = p; v.en = e; v.reload = r;
        v.lv = lv; v.cnt = c; v.busy = b; v.done = d; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [7:0] c,
                           input logic b, input logic d);
        chk({n, ".cnt"}, 32'(bus.o_cnt), 32'(c));
        chk({n, ".busy"}, 32'(bus.o_busy), 32'(b));
        chk({n, ".done"}, 32'(bus.o_done), 32'(d));
    endtask

    task automatic step(input logic s, input logic p, input logic e,
                        input logic r, input logic [7:0] lv);
        @(negedge clk);
        bus.i_start = s; bus.i_stop = p; bus.i_en = e;
        bus.i_reload = r; bus.i_load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_en = 1'b0;
        bus.i_reload = 1'b0; bus.i_load_val = '0;
        #1;
        chk_all("reset", 8'd0, 1'b0, 1'b0);

        // one-shot 5
        add(1,0,0,0,8'd5,   8'd5,1,0,"os_start");
        add(0,0,1,0,8'd0,   8'd4,1,0,"os_t1");
        add(0,0,1,0,8'd0,   8'd3,1,0,"os_t2");
        add(0,0,1,0,8'd0,   8'd2,1,0,"os_t3");
        add(0,0,1,0,8'd0,   8'd1,1,0,"os_t4");
        add(0,0,1,0,8'd0,   8'd0,0,1,"os_exp");
        add(0,0,1,0,8'd0,   8'd0,0,0,"os_idle");
        // auto-reload 3, tick every other cycle
        add(1,0,0,1,8'd3,   8'd3,1,0,"ar_start");
        add(0,0,1,0,8'd0,   8'd2,1,0,"ar_t1");
        add(0,0,0,0,8'd0,   8'd2,1,0,"ar_g1");
        add(0,0,1,0,8'd0,   8'd1,1,0,"ar_t2");
        add(0,0,0,0,8'd0,   8'd1,1,0,"ar_g2");
        add(0,0,1,0,8'd0,   8'd3,1,1,"ar_exp1");
        add(0,0,0,0,8'd0,   8'd3,1,0,"ar_g3");
        add(0,0,1,0,8'd0,   8'd2,1,0,"ar_t4");
        add(0,0,0,0,8'd0,   8'd2,1,0,"ar_g4");
        add(0,0,1,0,8'd0,   8'd1,1,0,"ar_t5");
        add(0,0,0,0,8'd0,   8'd1,1,0,"ar_g5");
        add(0,0,1,0,8'd0,   8'd3,1,1,"ar_exp2");
        // stop beats start and tick at cnt=1
        add(0,0,1,0,8'd0,   8'd2,1,0,"pr_t1");
        add(0,0,1,0,8'd0,   8'd1,1,0,"pr_t2");
        add(1,1,1,1,8'd7,   8'd1,0,0,"pr_stop");
        add(0,0,0,0,8'd0,   8'd1,0,0,"pr_hold");
        // start beats tick at cnt=1
        add(1,0,0,0,8'd2,   8'd2,1,0,"rs_start");
        add(0,0,1,0,8'd0,   8'd1,1,0,"rs_t1");
        add(1,0,1,0,8'd7,   8'd7,1,0,"rs_restart");
        add(0,0,1,0,8'd0,   8'd6,1,0,"rs_t2");
        add(0,1,0,0,8'd0,   8'd6,0,0,"rs_stop");
        add(0,0,1,1,8'd9,   8'd6,0,0,"rs_ignore");
        // zero load with reload mode
        add(1,0,1,1,8'd0,   8'd0,0,1,"z_start");
        add(0,0,1,0,8'd0,   8'd0,0,0,"z_after");
        // reload value 1, en held high
        add(1,0,1,1,8'd1,   8'd1,1,0,"r1_start");
        add(0,0,1,0,8'd0,   8'd1,1,1,"r1_e1");
        add(0,0,1,0,8'd0,   8'd1,1,1,"r1_e2");
        add(0,0,1,0,8'd0,   8'd1,1,1,"r1_e3");
        add(0,1,1,0,8'd0,   8'd1,0,0,"r1_stop");

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].en,
                 vecs[i].reload, vecs[i].lv);
            chk_all(vecs[i].name, vecs[i].cnt, vecs[i].busy,
                    vecs[i].done);
        end

        // full-range load expires after exactly 255 ticks
        step(1,0,0,0,8'd255);
        chk_all("max_start", 8'd255, 1'b1, 1'b0);
        for (int i = 1; i < 255; i++) begin
            step(0,0,1,0,8'd0);
            chk("max_cnt", 32'(bus.o_cnt), 32'(255 - i));
            chk("max_done", 32'(bus.o_done), 32'd0);
        end
        step(0,0,1,0,8'd0);
        chk_all("max_exp", 8'd0, 1'b0, 1'b1);

        // async reset mid-run
        step(1,0,0,0,8'd10);
        step(0,0,1,0,8'd0);
        step(0,0,1,0,8'd0);
        step(0,0,1,0,8'd0);
        chk_all("mr_pre", 8'd7, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mr_async", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0,0,1,0,8'd0);
        chk_all("mr_after", 8'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
